// File: rtl/combat_round_ctrl_if.sv
// DamageCalc handshake bundle: Start/Ack pulses out, Done plus damage totals back.
// No latency of its own; pure wiring between controller and DamageCalc.
// Done is level-held by DamageCalc until Ack, so no extra backpressure signalling.
interface combat_round_ctrl_if #(
    parameter int HP_W = 12
);
    logic            calc_start;
    logic            calc_ack;
    logic            calc_done;
    logic [HP_W-1:0] unit_dmg_total;
    logic [HP_W-1:0] enemy_dmg_total;

    modport master (
        output calc_start,
        output calc_ack,
        input  calc_done,
        input  unit_dmg_total,
        input  enemy_dmg_total
    );

    modport slave (
        input  calc_start,
        input  calc_ack,
        output calc_done,
        output unit_dmg_total,
        output enemy_dmg_total
    );
endinterface

// File: rtl/combat_round_ctrl.sv
// Per-round scheduler: Start DamageCalc, wait for Done, Ack, then apply damage to both base HPs.
// Tick->Start 1 cycle; Done seen at D -> Ack at D+1, HP/round_count visible at D+3.
// One tick may queue while a round is in flight; further ticks only flag tick_overrun.
module combat_round_ctrl #(
    parameter int HP_W    = 12,
    parameter int HP_INIT = 1000,
    parameter int TIMEOUT = 64,
    parameter int ROUND_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               round_tick,
    combat_round_ctrl_if.master calc,
    output logic [HP_W-1:0]    player_hp,
    output logic [HP_W-1:0]    enemy_hp,
    output logic [ROUND_W-1:0] round_count,
    output logic               busy,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               calc_timeout,
    output logic               tick_overrun
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_DONE = 3'd2;
    localparam logic [2:0] ACK       = 3'd3;
    localparam logic [2:0] APPLY     = 3'd4;
    localparam logic [2:0] OVER      = 3'd5;

    localparam int             CNT_W   = $clog2(TIMEOUT) + 1;
    localparam logic [HP_W-1:0] HP_RST = HP_W'(HP_INIT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic             pending;
    logic             abortFlag;
    logic [CNT_W-1:0] toCnt;
    logic [HP_W-1:0]  capUnit;
    logic [HP_W-1:0]  capEnemy;
    logic [HP_W-1:0]  newEnemyHp;
    logic [HP_W-1:0]  newPlayerHp;
    logic             inRound;
    logic             tickEn;
    logic             startReq;

    assign inRound  = (state == START) || (state == WAIT_DONE) || (state == ACK) || (state == APPLY);
    assign tickEn   = round_tick && enable;
    // A stale Done left high blocks a new round so it cannot be mistaken for this round's result.
    assign startReq = !calc.calc_done && (tickEn || pending);

    // Saturating subtract: compare first so the unsigned difference never wraps.
    always_comb begin
        newEnemyHp  = enemy_hp;
        newPlayerHp = player_hp;
        if (!abortFlag) begin
            newEnemyHp  = (enemy_hp  > capUnit)  ? enemy_hp  - capUnit  : '0;
            newPlayerHp = (player_hp > capEnemy) ? player_hp - capEnemy : '0;
        end
    end

    // Round sequencing, damage capture/apply and the timeout watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            abortFlag    <= 1'b0;
            toCnt        <= '0;
            capUnit      <= '0;
            capEnemy     <= '0;
            player_hp    <= HP_RST;
            enemy_hp     <= HP_RST;
            round_count  <= '0;
            calc_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startReq) begin
                        state <= START;
                    end
                end
                START: begin
                    toCnt     <= '0;
                    abortFlag <= 1'b0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    toCnt <= toCnt + 1'b1;
                    if (calc.calc_done) begin
                        capUnit  <= calc.unit_dmg_total;
                        capEnemy <= calc.enemy_dmg_total;
                        state    <= ACK;
                    end else if (toCnt == TO_LAST) begin
                        calc_timeout <= 1'b1;
                        abortFlag    <= 1'b1;
                        state        <= ACK;
                    end
                end
                ACK: begin
                    state <= APPLY;
                end
                APPLY: begin
                    enemy_hp  <= newEnemyHp;
                    player_hp <= newPlayerHp;
                    if (!abortFlag) begin
                        round_count <= round_count + 1'b1;
                    end
                    if ((newEnemyHp == '0) || (newPlayerHp == '0)) begin
                        state <= OVER;
                    end else begin
                        state <= IDLE;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Single-entry tick queue; a second queued tick is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 1'b0;
            tick_overrun <= 1'b0;
        end else if (state == OVER) begin
            pending <= 1'b0;
        end else if (state == IDLE) begin
            if (startReq) begin
                pending <= 1'b0;
            end
        end else if (inRound && tickEn) begin
            if (pending) begin
                tick_overrun <= 1'b1;
            end else begin
                pending <= 1'b1;
            end
        end
    end

    // Handshake pulses and status are decoded straight from the state register.
    always_comb begin
        calc.calc_start = (state == START);
        calc.calc_ack   = (state == ACK);
        busy            = inRound;
        game_over       = (state == OVER);
        winner          = 2'b00;
        if (state == OVER) begin
            winner = {player_hp == '0, enemy_hp == '0};
        end
    end
endmodule
